tis_exec_ctrl: RTL and testbench

//  Per-node execution controller for the TIS-100 datapath. Steps a program PC through an external

---
 rtl/tis_exec_ctrl.sv | 173 +++++++++++++++++
 tb/tb_tis_exec_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tis_exec_ctrl.sv
// TIS-100 node execution controller: fetches from an external ROM via pc, decodes,
// drives ACC/BAK register-file strobes, runs blocking IN/OUT handshakes and jumps.
module tis_exec_ctrl #(
  parameter int WORD_W   = 16,
  parameter int PROG_LEN = 16,
  parameter int PC_W     = $clog2(PROG_LEN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  output logic [PC_W-1:0]          pc,
  input  logic [31:0]              instr,
  input  logic signed [WORD_W-1:0] acc,
  output logic                     rf_write,
  output logic                     rf_swap,
  output logic                     rf_save,
  output logic signed [WORD_W-1:0] rf_wdata,
  input  logic signed [WORD_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [WORD_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     halted
);

  localparam logic [3:0] OP_MOV_ACC = 4'h1;
  localparam logic [3:0] OP_MOV_OUT = 4'h2;
  localparam logic [3:0] OP_ADD     = 4'h3;
  localparam logic [3:0] OP_SUB     = 4'h4;
  localparam logic [3:0] OP_NEG     = 4'h5;
  localparam logic [3:0] OP_SWP     = 4'h6;
  localparam logic [3:0] OP_SAV     = 4'h7;
  localparam logic [3:0] OP_JMP     = 4'h8;
  localparam logic [3:0] OP_JEZ     = 4'h9;
  localparam logic [3:0] OP_JNZ     = 4'hA;
  localparam logic [3:0] OP_JGZ     = 4'hB;
  localparam logic [3:0] OP_JLZ     = 4'hC;
  localparam logic [3:0] OP_HCF     = 4'hF;

  localparam logic [1:0] SRC_IMM = 2'd0;
  localparam logic [1:0] SRC_ACC = 2'd1;
  localparam logic [1:0] SRC_NIL = 2'd2;

  localparam logic signed [WORD_W:0] SAT_MAX = (WORD_W+1)'(999);
  localparam logic signed [WORD_W:0] SAT_MIN = -(WORD_W+1)'(999);

  typedef enum logic [1:0] {S_RUN, S_WAIT_OUT, S_HALT} state_t;

  state_t                     state_q;
  logic [PC_W-1:0]            pc_q, pc_d, pc_inc, tgt;
  logic signed [WORD_W-1:0]   out_data_q;
  logic                       out_valid_q, halted_q;

  logic [3:0]                 op;
  logic [1:0]                 src_sel;
  logic [31:0]                imm32;
  logic signed [WORD_W-1:0]   imm_val, src_val;
  logic                       uses_src, wants_in, run_en, commit;
  logic                       acc_zero, acc_neg, taken, tgt_oob;

  // Operands arrive one bit wider than the word so the clamp sees true overflow.
  function automatic logic signed [WORD_W-1:0] sat(input logic signed [WORD_W:0] v);
    if (v > SAT_MAX)      sat = SAT_MAX[WORD_W-1:0];
    else if (v < SAT_MIN) sat = SAT_MIN[WORD_W-1:0];
    else                  sat = v[WORD_W-1:0];
  endfunction

  always_comb begin
    op       = instr[31:28];
    src_sel  = instr[27:26];
    imm32    = {{16{instr[15]}}, instr[15:0]};
    imm_val  = sat({imm32[WORD_W-1], imm32[WORD_W-1:0]});

    case (src_sel)
      SRC_IMM: src_val = imm_val;
      SRC_ACC: src_val = acc;
      SRC_NIL: src_val = '0;
      default: src_val = in_data;
    endcase

    uses_src = (op == OP_MOV_ACC) || (op == OP_MOV_OUT) || (op == OP_ADD) || (op == OP_SUB);
    wants_in = uses_src && (src_sel == 2'd3);
    run_en   = (state_q == S_RUN) && en;
    in_ready = run_en && wants_in;
    commit   = run_en && (!wants_in || in_valid);

    acc_zero = (acc == '0);
    acc_neg  = acc[WORD_W-1];
    case (op)
      OP_JMP:  taken = 1'b1;
      OP_JEZ:  taken = acc_zero;
      OP_JNZ:  taken = !acc_zero;
      OP_JGZ:  taken = !acc_zero && !acc_neg;
      OP_JLZ:  taken = acc_neg;
      default: taken = 1'b0;
    endcase

    tgt     = instr[PC_W-1:0];
    tgt_oob = ({{(32-PC_W){1'b0}}, tgt} >= 32'(PROG_LEN));
    pc_inc  = (pc_q == PC_W'(PROG_LEN-1)) ? '0 : pc_q + 1'b1;
    pc_d    = taken ? (tgt_oob ? '0 : tgt) : pc_inc;

    rf_write = 1'b0;
    rf_swap  = 1'b0;
    rf_save  = 1'b0;
    rf_wdata = '0;
    if (commit) begin
      case (op)
        OP_MOV_ACC: begin rf_write = 1'b1; rf_wdata = src_val; end
        OP_ADD: begin
          rf_write = 1'b1;
          rf_wdata = sat({acc[WORD_W-1], acc} + {src_val[WORD_W-1], src_val});
        end
        OP_SUB: begin
          rf_write = 1'b1;
          rf_wdata = sat({acc[WORD_W-1], acc} - {src_val[WORD_W-1], src_val});
        end
        OP_NEG: begin
          rf_write = 1'b1;
          rf_wdata = sat(-$signed({acc[WORD_W-1], acc}));
        end
        OP_SWP:  rf_swap = 1'b1;
        OP_SAV:  rf_save = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      pc_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (commit) begin
            case (op)
              OP_MOV_OUT: begin
                out_data_q  <= src_val;
                out_valid_q <= 1'b1;
                state_q     <= S_WAIT_OUT;
              end
              OP_HCF: begin
                halted_q <= 1'b1;
                state_q  <= S_HALT;
              end
              default: pc_q <= pc_d;
            endcase
          end
        end
        // The OUT handshake completes regardless of en; pc moves past the MOV only then.
        S_WAIT_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            pc_q        <= pc_inc;
            state_q     <= S_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  assign pc        = pc_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_tis_exec_ctrl.sv
// Bench for tis_exec_ctrl: ROM and ACC/BAK register file around the DUT, an
// instruction-level reference model compared every cycle, plus directed literal checks.
module tb_tis_exec_ctrl;
  localparam int WW  = 16;
  localparam int PL  = 12;
  localparam int PCW = $clog2(PL);

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic signed [WW-1:0] in_data = '0;
  logic [31:0] instr;
  logic [PCW-1:0] pc;
  logic signed [WW-1:0] acc, bak, rf_wdata, out_data;
  logic rf_write, rf_swap, rf_save, in_ready, out_valid, halted;
  logic [31:0] rom [PL];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  tis_exec_ctrl #(.WORD_W(WW), .PROG_LEN(PL)) dut (
    .clk(clk), .rst(rst), .en(en), .pc(pc), .instr(instr), .acc(acc),
    .rf_write(rf_write), .rf_swap(rf_swap), .rf_save(rf_save), .rf_wdata(rf_wdata),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .halted(halted)
  );

  assign instr = rom[pc];

  // ACC/BAK register file driven by the DUT strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      bak <= '0;
    end else if (rf_write) acc <= rf_wdata;
    else if (rf_swap) begin
      acc <= bak;
      bak <= acc;
    end else if (rf_save) bak <= acc;
  end

  task automatic cmp(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clampi(int v);
    return (v > 999) ? 999 : ((v < -999) ? -999 : v);
  endfunction

  function automatic logic [31:0] enc(int op, int sel, int imm);
    return {op[3:0], sel[1:0], 10'b0, imm[15:0]};
  endfunction

  // Reference model: mode 0 = running, 1 = waiting on OUT, 2 = halted
  int m_pc, m_mode, m_acc, m_bak, m_od, m_ov, m_halt;
  int n_pc, n_mode, n_acc, n_bak, n_od, n_ov, n_halt;
  int e_wr, e_sw, e_sv, e_wd, e_inr;
  bit m_live = 1'b0;

  task automatic model_eval();
    logic [31:0] ins;
    int op, sel, sv, tgt;
    bit need_in, tk;
    ins = rom[m_pc];
    op  = int'(ins[31:28]);
    sel = int'(ins[27:26]);
    case (sel)
      0: sv = clampi(int'($signed(ins[15:0])));
      1: sv = m_acc;
      2: sv = 0;
      default: sv = int'(in_data);
    endcase
    e_wr = 0; e_sw = 0; e_sv = 0; e_wd = 0; e_inr = 0;
    n_pc = m_pc; n_mode = m_mode; n_acc = m_acc; n_bak = m_bak;
    n_od = m_od; n_ov = m_ov; n_halt = m_halt;
    if (m_mode == 0 && en) begin
      need_in = (op >= 1 && op <= 4) && sel == 3;
      e_inr = need_in ? 1 : 0;
      if (!need_in || in_valid) begin
        n_pc = (m_pc + 1) % PL;
        case (op)
          1: begin e_wr = 1; e_wd = sv; end
          2: begin n_od = sv; n_ov = 1; n_mode = 1; n_pc = m_pc; end
          3: begin e_wr = 1; e_wd = clampi(m_acc + sv); end
          4: begin e_wr = 1; e_wd = clampi(m_acc - sv); end
          5: begin e_wr = 1; e_wd = clampi(-m_acc); end
          6: begin e_sw = 1; n_acc = m_bak; n_bak = m_acc; end
          7: begin e_sv = 1; n_bak = m_acc; end
          8, 9, 10, 11, 12: begin
            tk  = (op == 8) || (op == 9 && m_acc == 0) || (op == 10 && m_acc != 0) ||
                  (op == 11 && m_acc > 0) || (op == 12 && m_acc < 0);
            tgt = int'(ins[15:0]) % (1 << PCW);
            if (tk) n_pc = (tgt >= PL) ? 0 : tgt;
          end
          15: begin n_halt = 1; n_mode = 2; n_pc = m_pc; end
          default: ;
        endcase
        if (e_wr) n_acc = e_wd;
      end
    end else if (m_mode == 1 && out_ready) begin
      n_ov = 0; n_mode = 0; n_pc = (m_pc + 1) % PL;
    end
  endtask

  always begin
    @(negedge clk);
    model_eval();
    if (m_live) begin
      cmp("pc", int'(pc), m_pc);
      cmp("out_valid", int'(out_valid), m_ov);
      cmp("out_data", int'(out_data), m_od);
      cmp("halted", int'(halted), m_halt);
      if (!rst) begin
        cmp("rf_write", int'(rf_write), e_wr);
        cmp("rf_swap", int'(rf_swap), e_sw);
        cmp("rf_save", int'(rf_save), e_sv);
        cmp("in_ready", int'(in_ready), e_inr);
        if (e_wr) cmp("rf_wdata", int'(rf_wdata), e_wd);
      end
    end
    @(posedge clk);
    if (rst) begin
      m_pc = 0; m_mode = 0; m_acc = 0; m_bak = 0; m_od = 0; m_ov = 0; m_halt = 0;
      m_live = 1'b1;
    end else if (m_live) begin
      m_pc = n_pc; m_mode = n_mode; m_acc = n_acc; m_bak = n_bak;
      m_od = n_od; m_ov = n_ov; m_halt = n_halt;
    end
  end

  task automatic go(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_rom();
    for (int k = 0; k < PL; k++) rom[k] = 32'h0;
  endtask

  task automatic reset_dut();
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    go(2);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    int op, sel, imm, pick;
    op = int'($urandom_range(0, 15));
    if (op == 15 && $urandom_range(0, 3) != 0) op = 0;
    sel  = int'($urandom_range(0, 3));
    pick = int'($urandom_range(0, 4));
    case (pick)
      0: imm = int'($urandom_range(0, 40)) - 20;
      1: imm = int'($urandom_range(900, 1100));
      2: imm = -int'($urandom_range(900, 1100));
      3: imm = ($urandom_range(0, 1) != 0) ? 32'h7FFF : 32'h8000;
      default: imm = int'($urandom_range(0, 65535));
    endcase
    return enc(op, sel, imm);
  endfunction

  initial begin
    int v;
    clear_rom();

    // Dependent ALU chain
    rom[0] = enc(1, 0, 5); rom[1] = enc(3, 0, 7); rom[2] = enc(4, 0, 20);
    reset_dut(); en = 1'b1;
    #1; cmp("t1 pc0", int'(pc), 0); cmp("t1 wd0", int'(rf_wdata), 5);
    go(1); #1; cmp("t1 pc1", int'(pc), 1); cmp("t1 wd1", int'(rf_wdata), 12);
    go(1); #1; cmp("t1 pc2", int'(pc), 2); cmp("t1 wd2", int'(rf_wdata), -8);
    go(1); #1; cmp("t1 pc3", int'(pc), 3);

    // Saturation
    clear_rom();
    rom[0] = enc(1, 0, 990);  rom[1] = enc(3, 0, 50);
    rom[2] = enc(1, 0, -990); rom[3] = enc(4, 0, 50);
    rom[4] = enc(1, 0, 32'h7FFF); rom[5] = enc(1, 0, 32'h8000);
    reset_dut(); en = 1'b1;
    go(1); #1; cmp("t2 add sat", int'(rf_wdata), 999);
    go(2); #1; cmp("t2 sub sat", int'(rf_wdata), -999);
    go(1); #1; cmp("t2 imm pos", int'(rf_wdata), 999);
    go(1); #1; cmp("t2 imm neg", int'(rf_wdata), -999);

    // IN stall then transfer
    clear_rom();
    rom[0] = enc(1, 3, 0);
    reset_dut(); en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; cmp("t3 stall pc", int'(pc), 0); cmp("t3 in_ready", int'(in_ready), 1);
      cmp("t3 no write", int'(rf_write), 0);
      go(1);
    end
    in_valid = 1'b1; in_data = 16'sd42;
    #1; cmp("t3 write", int'(rf_write), 1); cmp("t3 wdata", int'(rf_wdata), 42);
    go(1); in_valid = 1'b0;
    #1; cmp("t3 pc", int'(pc), 1);

    // OUT handshake and reset during the wait
    clear_rom();
    rom[0] = enc(2, 0, 9); rom[1] = enc(2, 0, 3);
    reset_dut(); en = 1'b1;
    #1; cmp("t4 ov idle", int'(out_valid), 0);
    go(1);
    for (int i = 0; i < 4; i++) begin
      #1; cmp("t4 ov", int'(out_valid), 1); cmp("t4 od", int'(out_data), 9);
      cmp("t4 pc held", int'(pc), 0);
      go(1);
    end
    out_ready = 1'b1;
    go(1); out_ready = 1'b0;
    #1; cmp("t4 ov drop", int'(out_valid), 0); cmp("t4 pc adv", int'(pc), 1);
    go(1);
    #1; cmp("t4 ov2", int'(out_valid), 1); cmp("t4 od2", int'(out_data), 3);
    rst = 1'b1;
    go(1); rst = 1'b0;
    #1; cmp("t4 rst ov", int'(out_valid), 0); cmp("t4 rst pc", int'(pc), 0);
    cmp("t4 rst od", int'(out_data), 0);

    // Wrap and jumps
    clear_rom();
    rom[0] = enc(8, 0, 11);
    reset_dut(); en = 1'b1;
    go(1); #1; cmp("t5 jmp", int'(pc), 11);
    go(1); #1; cmp("t5 wrap", int'(pc), 0);
    clear_rom();
    rom[0] = enc(9, 0, 2); rom[2] = enc(1, 0, 1); rom[3] = enc(9, 0, 7); rom[4] = enc(8, 0, 14);
    reset_dut(); en = 1'b1;
    go(1); #1; cmp("t5 jez taken", int'(pc), 2);
    go(2); #1; cmp("t5 jez not", int'(pc), 4);
    go(1); #1; cmp("t5 jmp oob", int'(pc), 0);

    // SAV, SWP, HCF
    clear_rom();
    rom[0] = enc(1, 0, 3); rom[1] = enc(7, 0, 0); rom[2] = enc(6, 0, 0); rom[3] = enc(15, 0, 0);
    reset_dut(); en = 1'b1;
    go(1); #1; cmp("t6 sav", int'(rf_save), 1); cmp("t6 sav only", int'(rf_swap | rf_write), 0);
    go(1); #1; cmp("t6 swp", int'(rf_swap), 1); cmp("t6 swp only", int'(rf_save | rf_write), 0);
    go(2);
    for (int i = 0; i < 10; i++) begin
      en = $urandom_range(0, 1) != 0;
      #1; cmp("t6 halted", int'(halted), 1); cmp("t6 pc frozen", int'(pc), 3);
      cmp("t6 no strobe", int'(rf_write | rf_swap | rf_save), 0);
      go(1);
    end

    // Randomized programs and handshakes
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < PL; k++) rom[k] = rand_instr();
      reset_dut();
      for (int c = 0; c < 300; c++) begin
        en        = $urandom_range(0, 9) != 0;
        in_valid  = $urandom_range(0, 2) != 0;
        out_ready = $urandom_range(0, 2) != 0;
        v = int'($urandom_range(0, 1998)) - 999;
        in_data = v[WW-1:0];
        if (c == 150 && r % 3 == 0) rst = 1'b1;
        else rst = 1'b0;
        go(1);
      end
    end
    rst = 1'b0;
    go(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
